// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, credit-limited memory requests,
// in-order instruction FIFO and redirect flush with stale-response discard.
// Ports: clk/rst (sync active-high); imem_req_* request channel; imem_resp_*
// response channel (in order, never back-pressured); redirect_valid/redirect_pc
// control-flow redirect; out_valid/out_ready/out_instr/out_pc decode handshake;
// fetch_misalign sticky trap flag (present only with FETCH_MISALIGN_TRAP_EN).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
  logic [31:0]   r_pc;
  logic [31:0]   r_fifo_pc    [DEPTH];
  logic [31:0]   r_fifo_instr [DEPTH];
  logic [31:0]   r_pend       [DEPTH];
  logic [AW-1:0] r_rd, r_wr, r_pend_rd, r_pend_wr;
  logic [CW-1:0] r_count, r_outst, r_discard;
  logic          w_trap, w_pop_raw, w_pop, w_push, w_issue, w_credit;
  logic [31:0]   w_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap         = r_misalign;
  assign fetch_misalign = r_misalign;
  assign w_target       = redirect_pc;
  always_ff @(posedge clk) begin
    if (rst)
      r_misalign <= 1'b0;
    else if (redirect_valid)
      r_misalign <= redirect_pc[1:0] != 2'b00;
  end
`else
  assign w_trap   = 1'b0;
  assign w_target = redirect_pc & ~32'h3;
`endif
  // occupancy counts buffered words plus every in-flight request, stale or not,
  // so a response always has a FIFO slot waiting for it
  assign out_valid      = (r_count != '0) && !w_trap;
  assign w_pop_raw      = out_valid && out_ready;
  assign w_credit       = ({1'b0, r_count} + {1'b0, r_outst} - {{CW{1'b0}}, w_pop_raw}) < DEPTH_W;
  assign imem_req_valid = !rst && !redirect_valid && !w_trap && w_credit;
  assign imem_req_addr  = r_pc;
  assign w_issue        = imem_req_valid && imem_req_ready;
  assign w_pop          = w_pop_raw && !redirect_valid;
  assign w_push         = imem_resp_valid && (r_discard == '0) && !redirect_valid;
  assign out_instr      = r_fifo_instr[r_rd];
  // while trapped, r_pc still holds the faulting redirect target
  assign out_pc         = w_trap ? r_pc : r_fifo_pc[r_rd];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc      <= RESET_PC;
      r_rd      <= '0;
      r_wr      <= '0;
      r_pend_rd <= '0;
      r_pend_wr <= '0;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst <= r_outst + CW'(w_issue) - CW'(imem_resp_valid);
      // every response retires its pending PC, including dropped ones
      if (imem_resp_valid)
        r_pend_rd <= r_pend_rd + AW'(1);
      if (w_issue)
        r_pend_wr <= r_pend_wr + AW'(1);
      if (redirect_valid) begin
        r_pc      <= w_target;
        r_count   <= '0;
        r_rd      <= r_wr;
        r_discard <= r_outst - CW'(imem_resp_valid);
      end else begin
        if (w_issue)
          r_pc <= r_pc + 32'd4;
        if (w_push)
          r_wr <= r_wr + AW'(1);
        if (w_pop)
          r_rd <= r_rd + AW'(1);
        r_count   <= r_count + CW'(w_push) - CW'(w_pop);
        r_discard <= r_discard - CW'(imem_resp_valid && (r_discard != '0));
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_issue)
      r_pend[r_pend_wr] <= r_pc;
    if (w_push) begin
      r_fifo_pc[r_wr]    <= r_pend[r_pend_rd];
      r_fifo_instr[r_wr] <= imem_resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, directed and randomized checks of fetch_unit
// against a stream-level reference model and an in-order latency memory model.
module tb_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_1000;
  localparam int DEPTH = 2;
  logic clk, rst;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid;
  logic out_valid, out_ready;
  logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_instr, out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misalign;
`endif
  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } mreq_t;
  typedef struct { bit rst; bit ordy; bit rv; logic [31:0] addr; bit ov; logic [31:0] opc; } vec_t;
  mreq_t memq[$];
  vec_t  tab[$];
  int cyc = 0, lat = 1, rdy_pct = 100, vecs = 0, errs = 0;
  logic [31:0] exp_fetch, exp_deliver, trap_pc;
  int buf_n;
  bit trap;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_fetch = RPC; exp_deliver = RPC; buf_n = 0; trap = 0;
    memq.delete();
  endtask

  // One clock: check at negedge, then update memory and model after posedge.
  task automatic cycle(input int ti = -1);
    int occ;
    bit s_req, s_resp, s_pop, s_redir, st;
    logic [31:0] s_raddr, s_rpc, tgt;
    @(negedge clk);
    if (ti >= 0) begin
      chk("tab_req_valid", imem_req_valid, tab[ti].rv);
      if (tab[ti].rv) chk("tab_req_addr", imem_req_addr, tab[ti].addr);
      if (!tab[ti].rst) chk("tab_out_valid", out_valid, tab[ti].ov);
      if (tab[ti].ov) chk("tab_out_pc", out_pc, tab[ti].opc);
    end
    if (!rst) begin
      occ = memq.size() + buf_n - ((!trap && buf_n > 0 && out_ready) ? 1 : 0);
      chk("req_valid", imem_req_valid, !redirect_valid && !trap && occ < DEPTH);
      chk("out_valid", out_valid, !trap && buf_n > 0);
      if (!trap && buf_n > 0) begin
        chk("out_pc", out_pc, exp_deliver);
        chk("out_instr", out_instr, instr_of(exp_deliver));
      end
      if (trap) chk("trap_pc", out_pc, trap_pc);
      if (imem_req_valid && imem_req_ready) chk("req_addr", imem_req_addr, exp_fetch);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("fetch_misalign", fetch_misalign, trap);
`endif
    end
    s_req = imem_req_valid && imem_req_ready; s_resp = imem_resp_valid;
    s_pop = out_valid && out_ready && !redirect_valid; s_redir = redirect_valid;
    s_raddr = imem_req_addr; s_rpc = redirect_pc;
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      st = 1;
      if (s_resp && memq.size() > 0) begin st = memq[0].stale; void'(memq.pop_front()); end
      if (s_redir) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt = s_rpc; trap = tgt[1:0] != 2'b00; trap_pc = tgt;
`else
        tgt = s_rpc & ~32'h3;
`endif
        exp_fetch = tgt; exp_deliver = tgt; buf_n = 0;
        foreach (memq[i]) memq[i].stale = 1;
      end else begin
        if (s_req) exp_fetch += 32'd4;
        if (s_pop) begin buf_n--; exp_deliver += 32'd4; end
        if (s_resp && !st) buf_n++;
      end
      if (s_req) memq.push_back('{s_raddr, cyc + lat, 1'b0});
    end
    cyc++;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_resp_valid = 1; imem_resp_data = instr_of(memq[0].addr);
    end else begin
      imem_resp_valid = 0; imem_resp_data = $urandom;
    end
    imem_req_ready = $urandom_range(99) < rdy_pct;
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1; redirect_pc = t;
    cycle();
    redirect_valid = 0;
    #1;
  endtask

  task automatic wait_for(input string name, input int which);
    int n = 0;
    while (n < 30 && !((which == 0) ? (imem_resp_valid && out_valid) : out_valid)) begin
      cycle(); n++;
    end
    chk(name, (which == 0) ? (imem_resp_valid && out_valid) : out_valid, 1);
  endtask

  initial begin
    rst = 1; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
    imem_req_ready = 1; imem_resp_valid = 0; imem_resp_data = 0;
    model_reset();
    tab.push_back('{0,1,1,32'h1000,0,0});
    tab.push_back('{0,1,1,32'h1004,0,0});
    tab.push_back('{0,1,1,32'h1008,1,32'h1000});
    tab.push_back('{0,1,1,32'h100c,1,32'h1004});
    tab.push_back('{0,1,1,32'h1010,1,32'h1008});
    tab.push_back('{1,1,0,0,0,0});
    tab.push_back('{0,0,1,32'h1000,0,0});
    tab.push_back('{0,0,1,32'h1004,0,0});
    for (int i = 0; i < 8; i++) tab.push_back('{0,0,0,0,1,32'h1000});
    tab.push_back('{0,1,1,32'h1008,1,32'h1000});
    tab.push_back('{0,1,1,32'h100c,1,32'h1004});
    tab.push_back('{0,1,1,32'h1010,1,32'h1008});
    tab.push_back('{0,1,1,32'h1014,1,32'h100c});
    cycle(); cycle();
    foreach (tab[i]) begin
      rst = tab[i].rst; out_ready = tab[i].ordy;
      cycle(i);
    end
    // stale responses under 3-cycle latency
    rst = 1; lat = 3; out_ready = 1; cycle(); rst = 0;
    for (int n = 0; n < 10 && memq.size() < 2; n++) cycle();
    redirect(32'h2000);
    wait_for("wait_redir_out", 1);
    chk("redir_first_pc", out_pc, 32'h2000);
    // redirect coincident with a response and a pop
    lat = 1;
    for (int n = 0; n < 8; n++) cycle();
    wait_for("wait_resp_pop", 0);
    redirect(32'h2000);
    chk("flush_out_valid", out_valid, 0);
    chk("r1_req_valid", imem_req_valid, 1);
    chk("r1_req_addr", imem_req_addr, 32'h2000);
    // PC wrap
    for (int n = 0; n < 8; n++) cycle();
    redirect(32'hFFFF_FFFC);
    chk("wrap_req0_valid", imem_req_valid, 1);
    chk("wrap_req0_addr", imem_req_addr, 32'hFFFF_FFFC);
    cycle(); #1;
    chk("wrap_req1_valid", imem_req_valid, 1);
    chk("wrap_req1_addr", imem_req_addr, 32'h0000_0000);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int n = 0; n < 4; n++) cycle();
    redirect(32'h3002);
    for (int n = 0; n < 5; n++) begin
      chk("mis_flag", fetch_misalign, 1);
      chk("mis_req_valid", imem_req_valid, 0);
      chk("mis_out_valid", out_valid, 0);
      chk("mis_out_pc", out_pc, 32'h3002);
      cycle(); #1;
    end
    redirect(32'h3000);
    chk("mis_clear", fetch_misalign, 0);
    chk("mis_resume_valid", imem_req_valid, 1);
    chk("mis_resume_addr", imem_req_addr, 32'h3000);
`endif
    // randomized segments
    for (int s = 0; s < 8; s++) begin
      lat = $urandom_range(1, 4); rdy_pct = $urandom_range(40, 100);
      for (int n = 0; n < 300; n++) begin
        out_ready = $urandom_range(99) < 70;
        redirect_valid = $urandom_range(99) < 4;
`ifdef FETCH_MISALIGN_TRAP_EN
        redirect_pc = ($urandom_range(99) < 30) ? (($urandom & ~32'h3) | 32'h2) : ($urandom & ~32'h3);
`else
        redirect_pc = ($urandom_range(99) < 30) ? $urandom : ($urandom & ~32'h3);
`endif
        cycle();
      end
      redirect_valid = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
